// File: rtl/seq_pkg.sv
// Shared definitions for the instruction sequencer: state encoding, opcodes,
// register codes and the instruction-kind classifier. SEQ_STEP_EN adds STEP_WAIT.
package seq_pkg;

    typedef logic [2:0] seq_state_t;

    localparam seq_state_t ST_IDLE      = 3'd0;
    localparam seq_state_t ST_FETCH     = 3'd1;
    localparam seq_state_t ST_DECODE    = 3'd2;
    localparam seq_state_t ST_FETCH_IMM = 3'd3;
    localparam seq_state_t ST_EXEC      = 3'd4;
    localparam seq_state_t ST_HALTED    = 3'd5;
`ifdef SEQ_STEP_EN
    localparam seq_state_t ST_STEP_WAIT = 3'd6;
`endif

    localparam logic [7:0] OP_ADD    = 8'h00;
    localparam logic [7:0] OP_SUB    = 8'h01;
    localparam logic [7:0] OP_AND    = 8'h02;
    localparam logic [7:0] OP_OR     = 8'h03;
    localparam logic [7:0] OP_XOR    = 8'h04;
    localparam logic [7:0] OP_NOT    = 8'h05;
    localparam logic [7:0] OP_SHL    = 8'h06;
    localparam logic [7:0] OP_SHR    = 8'h07;
    localparam logic [7:0] OP_CMP    = 8'h08;
    localparam logic [7:0] OP_INC    = 8'h0F;
    localparam logic [7:0] OP_DEC    = 8'h10;
    localparam logic [7:0] OP_HALT   = 8'hFD;
    localparam logic [7:0] OP_LDI    = 8'hFE;
    localparam logic [7:0] OP_MOV_RR = 8'hFF;

    localparam logic [3:0] REG_RA  = 4'h0;
    localparam logic [3:0] REG_RB  = 4'h1;
    localparam logic [3:0] REG_RC  = 4'h2;
    localparam logic [3:0] REG_RD  = 4'h3;
    localparam logic [3:0] REG_RE  = 4'h4;
    localparam logic [3:0] REG_RF  = 4'h5;
    localparam logic [3:0] REG_RBP = 4'h6;
    localparam logic [3:0] REG_RSP = 4'h7;

    typedef enum logic [1:0] {
        KIND_ALU  = 2'd0,
        KIND_LDI  = 2'd1,
        KIND_HALT = 2'd2
    } instr_kind_e;

    // Everything that is not LDI or HALT is handed to the ALU as a register op.
    function automatic instr_kind_e classify(input logic [7:0] option);
        case (option)
            OP_LDI:  return KIND_LDI;
            OP_HALT: return KIND_HALT;
            default: return KIND_ALU;
        endcase
    endfunction

endpackage

// File: rtl/seq_decode.sv
// Combinational instruction decoder: splits a fetched word into its
// option and selector fields and classifies it as ALU, LDI or HALT.
module seq_decode
    import seq_pkg::*;
(
    input  logic [15:0]  word_i,
    output instr_kind_e  kind_o,
    output logic [7:0]   selector_o,
    output logic [7:0]   option_o
);

    assign option_o   = word_i[15:8];
    assign selector_o = word_i[7:0];
    assign kind_o     = classify(word_i[15:8]);

endmodule

// File: rtl/instr_sequencer.sv
// Instruction sequencer: fetches words from program memory, decodes them and
// strobes the ALU. Define SEQ_STEP_EN to add single-step gating via i_step.
module instr_sequencer
    import seq_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        i_start,
`ifdef SEQ_STEP_EN
    input  logic        i_step,
`endif
    output logic        o_mem_req,
    output logic [15:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [15:0] i_mem_data,
    output logic [7:0]  o_reg_selector,
    output logic [7:0]  o_option,
    output logic        o_regop,
    output logic        o_store_in_reg,
    output logic [15:0] o_data,
    output logic [15:0] o_pc,
    output logic        o_busy,
    output logic        o_halted
);

    seq_state_t  state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] word_q, word_d;
    logic [15:0] data_q, data_d;
    logic [7:0]  sel_q, sel_d;
    logic [7:0]  opt_q, opt_d;
    instr_kind_e kind_q, kind_d;

    instr_kind_e dec_kind;
    logic [7:0]  dec_sel;
    logic [7:0]  dec_opt;

    seq_decode u_decode (
        .word_i     (word_q),
        .kind_o     (dec_kind),
        .selector_o (dec_sel),
        .option_o   (dec_opt)
    );

    always_comb begin
        // NOTE: every _d starts from its _q, so no branch can leave a latch behind.
        state_d = state_q;
        pc_d    = pc_q;
        word_d  = word_q;
        data_d  = data_q;
        sel_d   = sel_q;
        opt_d   = opt_q;
        kind_d  = kind_q;

        case (state_q)
            ST_IDLE, ST_HALTED: begin
                if (i_start) state_d = ST_FETCH;
            end
            ST_FETCH: begin
                if (i_mem_ack) begin
                    word_d  = i_mem_data;
                    pc_d    = pc_q + 16'd1;
                    state_d = ST_DECODE;
                end
            end
            ST_DECODE: begin
                sel_d  = dec_sel;
                opt_d  = dec_opt;
                kind_d = dec_kind;
                case (dec_kind)
                    KIND_LDI:  state_d = ST_FETCH_IMM;
                    KIND_HALT: state_d = ST_HALTED;
                    default:   state_d = ST_EXEC;
                endcase
            end
            ST_FETCH_IMM: begin
                // The PC simply rolls over, so an immediate at 16'h0000 after FFFF is fine.
                if (i_mem_ack) begin
                    data_d  = i_mem_data;
                    pc_d    = pc_q + 16'd1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
`ifdef SEQ_STEP_EN
                state_d = ST_STEP_WAIT;
`else
                state_d = ST_FETCH;
`endif
            end
`ifdef SEQ_STEP_EN
            ST_STEP_WAIT: begin
                if (i_step) state_d = ST_FETCH;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            state_q <= ST_IDLE;
            pc_q    <= 16'h0000;
            word_q  <= 16'h0000;
            data_q  <= 16'h0000;
            sel_q   <= 8'h00;
            opt_q   <= 8'h00;
            kind_q  <= KIND_ALU;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            word_q  <= word_d;
            data_q  <= data_d;
            sel_q   <= sel_d;
            opt_q   <= opt_d;
            kind_q  <= kind_d;
        end
    end

    // All outputs are decoded from registers, so reset clears them on the same edge.
    assign o_mem_req      = (state_q == ST_FETCH) || (state_q == ST_FETCH_IMM);
    assign o_mem_addr     = pc_q;
    assign o_reg_selector = sel_q;
    assign o_option       = opt_q;
    assign o_regop        = (state_q == ST_EXEC) && (kind_q == KIND_ALU);
    assign o_store_in_reg = (state_q == ST_EXEC) && (kind_q == KIND_LDI);
    assign o_data         = data_q;
    assign o_pc           = pc_q;
    assign o_busy         = (state_q != ST_IDLE) && (state_q != ST_HALTED);
    assign o_halted       = (state_q == ST_HALTED);

endmodule
